// File: rtl/ef_i2s_tx_pkg.sv
// Shared constants and the sample-alignment helper for the ef_i2s_tx transmitter.
package ef_i2s_pkg;

  localparam logic [1:0]  CH_LEFT   = 2'b10;
  localparam logic [1:0]  CH_RIGHT  = 2'b01;
  localparam logic [1:0]  CH_STEREO = 2'b11;
  localparam int unsigned SLOT_BITS = 32;
  localparam logic        WS_LEFT   = 1'b0;

  // Left shift that moves an LSB-aligned sample of 'size' bits up to the slot MSB.
  // A size of 0 (or anything beyond a full slot) means a full 32-bit sample.
  function automatic logic [4:0] msb_align_shift(input logic [5:0] size);
    if (size == 6'd0 || size >= 6'(SLOT_BITS)) return 5'd0;
    return 5'(6'(SLOT_BITS) - size);
  endfunction

endpackage

// File: rtl/ef_i2s_tx_if.sv
// Host-side FIFO bus of the I2S transmitter: push/flush controls and level status.
interface ef_i2s_tx_if #(
  parameter int DW = 32,
  parameter int AW = 4
);

  logic          fifo_wr;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_clr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_level;
  logic [AW:0]   fifo_level_threshold;
  logic          fifo_level_below;

  modport master (
    output fifo_wr, fifo_wdata, fifo_clr, fifo_level_threshold,
    input  fifo_full, fifo_empty, fifo_level, fifo_level_below
  );

  modport slave (
    input  fifo_wr, fifo_wdata, fifo_clr, fifo_level_threshold,
    output fifo_full, fifo_empty, fifo_level, fifo_level_below
  );

endinterface

// File: rtl/ef_i2s_tx_fifo.sv
// Synchronous first-word-fall-through sample FIFO with level, full/empty and flush.
module i2s_tx_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_do_rd;
  logic          w_do_wr;

  always_comb begin
    o_full  = (r_level == DEPTH);
    o_empty = (r_level == '0);
    o_level = r_level;
    o_rdata = r_mem[r_rptr];
    w_do_rd = i_rd && !o_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    w_do_wr = i_wr && (!o_full || w_do_rd);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr && !i_clr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/ef_i2s_tx.sv
// I2S master transmitter: SCK/WS generation, slot load control, MSB-first
// serializer and sticky underflow flag in front of a FWFT sample FIFO.
module ef_i2s_tx
  import ef_i2s_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic       o_sck,
  output logic       o_ws,
  output logic       o_sdo,
  input  logic       i_left_justified,
  input  logic [5:0] i_sample_size,
  input  logic [7:0] i_sck_prescaler,
  input  logic [1:0] i_channels,
  output logic       o_underflow,
  input  logic       i_underflow_clr,
  ef_i2s_tx_if.slave bus
);

  logic [7:0]           r_presc;
  logic                 r_sck;
  logic                 r_ws;
  logic [4:0]           r_bit_ctr;
  logic [SLOT_BITS-1:0] r_shift;
  logic                 r_sdo_d;
  logic                 r_lj;
  logic                 r_underflow;

  logic                 w_tick;
  logic                 w_fall;
  logic                 w_slot_start;
  logic                 w_new_ws;
  logic                 w_slot_en;
  logic                 w_pop;
  logic                 w_uf_set;
  logic [SLOT_BITS-1:0] w_load;
  logic [DW-1:0]        w_rdata;
  logic                 w_full;
  logic                 w_empty;
  logic [AW:0]          w_level;

  i2s_tx_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (bus.fifo_clr),
    .i_wr    (bus.fifo_wr),
    .i_wdata (bus.fifo_wdata),
    .i_rd    (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_tick       = i_en && (r_presc == '0);
    w_fall       = w_tick && r_sck;
    w_slot_start = w_fall && (r_bit_ctr == '0);
    w_new_ws     = ~r_ws;
    w_slot_en    = |(i_channels & ((w_new_ws == WS_LEFT) ? CH_LEFT : CH_RIGHT));
    w_pop        = w_slot_start && w_slot_en && !w_empty;
    w_uf_set     = w_slot_start && w_slot_en && w_empty;
    w_load       = SLOT_BITS'(w_rdata << msb_align_shift(i_sample_size));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b1;
      r_bit_ctr <= '0;
      r_shift   <= '0;
      r_sdo_d   <= 1'b0;
      r_lj      <= 1'b0;
    end else if (!i_en) begin
      r_presc   <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b1;
      r_bit_ctr <= '0;
      r_shift   <= '0;
      r_sdo_d   <= 1'b0;
    end else begin
      if (w_tick) begin
        r_presc <= i_sck_prescaler;
        r_sck   <= ~r_sck;
      end else begin
        r_presc <= r_presc - 8'd1;
      end
      if (w_fall) begin
        r_bit_ctr <= r_bit_ctr + 5'd1;
        // I2S delay flop sees the pre-edge MSB, so a word's LSB spills into the next slot.
        r_sdo_d   <= r_shift[SLOT_BITS-1];
        if (w_slot_start) begin
          r_ws    <= w_new_ws;
          r_lj    <= i_left_justified;
          r_shift <= w_pop ? w_load : '0;
        end else begin
          r_shift <= {r_shift[SLOT_BITS-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_underflow <= 1'b0;
    else if (w_uf_set)        r_underflow <= 1'b1;
    else if (i_underflow_clr) r_underflow <= 1'b0;
  end

  always_comb begin
    o_sck                = r_sck;
    o_ws                 = r_ws;
    o_sdo                = r_lj ? r_shift[SLOT_BITS-1] : r_sdo_d;
    o_underflow          = r_underflow;
    bus.fifo_full        = w_full;
    bus.fifo_empty       = w_empty;
    bus.fifo_level       = w_level;
    bus.fifo_level_below = (w_level < bus.fifo_level_threshold);
  end

endmodule

// File: tb/tb_ef_i2s_tx.sv
// Directed bench for ef_i2s_tx: a rising-SCK receiver model rebuilds slot words
// and a scoreboard compares them with the words expected from the pushed samples.
module tb_ef_i2s_tx;
  import ef_i2s_pkg::*;

  typedef struct packed {
    logic        ws;
    logic [31:0] w;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       lj = 1'b0;
  logic       uf_clr = 1'b0;
  logic [5:0] ssz = 6'd16;
  logic [7:0] presc = 8'd1;
  logic [1:0] ch = CH_STEREO;
  logic       sck, ws, sdo, uf;

  int vectors = 0;
  int miscompares = 0;

  slot_t exp_q[$];
  slot_t cap_q[$];

  int          mon_gen = 0;
  int          mon_seen = 0;
  logic        mon_lj = 1'b0;
  logic [31:0] m_sr = '0;
  logic        m_last_ws = 1'b1;
  logic        m_prev_sck = 1'b0;
  int          m_cnt = 0;
  int          m_nbits = 0;

  ef_i2s_tx_if #(.DW(32), .AW(4)) bus ();

  ef_i2s_tx #(.DW(32), .AW(4)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_en             (en),
    .o_sck            (sck),
    .o_ws             (ws),
    .o_sdo            (sdo),
    .i_left_justified (lj),
    .i_sample_size    (ssz),
    .i_sck_prescaler  (presc),
    .i_channels       (ch),
    .o_underflow      (uf),
    .i_underflow_clr  (uf_clr),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  function automatic slot_t mk(input logic s, input logic [31:0] w);
    slot_t r;
    r.ws = s;
    r.w  = w;
    return r;
  endfunction

  // Receiver model: samples on rising SCK; a word is the 32 bits starting at the
  // ws change (left-justified) or one SCK after it (I2S).
  always @(negedge clk) begin
    if (mon_gen != mon_seen) begin
      mon_seen   = mon_gen;
      m_last_ws  = 1'b1;
      m_cnt      = 0;
      m_nbits    = 0;
      m_prev_sck = sck;
      cap_q.delete();
    end else begin
      if (!m_prev_sck && sck) begin
        m_sr = {m_sr[30:0], sdo};
        m_nbits++;
        if (ws != m_last_ws) begin
          if (!mon_lj && m_nbits > 32) cap_q.push_back(mk(m_last_ws, m_sr));
          m_cnt     = 0;
          m_last_ws = ws;
        end else begin
          m_cnt++;
        end
        if (mon_lj && m_cnt == 31 && m_nbits >= 32) cap_q.push_back(mk(ws, m_sr));
      end
      m_prev_sck = sck;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed no summary, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.fifo_wr    = 1'b1;
    bus.fifo_wdata = w;
    @(negedge clk);
    bus.fifo_wr    = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    logic p;
    p = sck;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (!p && sck) break;
      p = sck;
    end
  endtask

  task automatic wait_ws(input logic tgt, input string tag);
    int cyc;
    cyc = 0;
    while (ws !== tgt && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 64'(ws), 64'(tgt));
  endtask

  task automatic next_cap(input string tag, output slot_t o, output bit got);
    int cyc;
    cyc = 0;
    o   = '0;
    while (cap_q.size() == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    got = (cap_q.size() != 0);
    if (got) o = cap_q.pop_front();
    else     chk({tag, "_timeout"}, 64'(cap_q.size()), 64'(1));
  endtask

  task automatic drain(input string tag);
    slot_t e, o;
    bit    got;
    int    n;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      next_cap(tag, o, got);
      if (got) chk($sformatf("%s[%0d]", tag, n), 64'(o), 64'(e));
      n++;
    end
  endtask

  function automatic int lvl_after(input int n);
    if (n % 2 == 1) return 4 - (n + 1) / 2;
    return (n / 2 + 1 >= 4) ? 0 : 3 - n / 2;
  endfunction

  initial begin
    int          n;
    logic        acc;
    slot_t       e, o;
    bit          got;
    logic [31:0] w4 [4];
    logic [31:0] w;

    bus.fifo_wr              = 1'b0;
    bus.fifo_wdata           = '0;
    bus.fifo_clr             = 1'b0;
    bus.fifo_level_threshold = 5'd8;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sck", 64'(sck), 64'(0));
    chk("rst_ws", 64'(ws), 64'(1));
    chk("rst_sdo", 64'(sdo), 64'(0));
    chk("rst_uf", 64'(uf), 64'(0));
    chk("rst_empty", 64'(bus.fifo_empty), 64'(1));
    chk("rst_level", 64'(bus.fifo_level), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Empty FIFO, stereo: first fall drops ws to left, underflow, silent sdo
    en = 1'b1;
    wait_ws(1'b0, "first_ws_left");
    chk("ws_on_fall_sck", 64'(sck), 64'(0));
    chk("first_uf", 64'(uf), 64'(1));
    wait_rise(n);
    wait_rise(n);
    chk("sck_period", 64'(n), 64'(4));
    acc = 1'b0;
    repeat (64) begin
      @(negedge clk);
      acc = acc | sdo;
    end
    chk("sdo_quiet", 64'(acc), 64'(0));
    chk("mid_left_ws", 64'(ws), 64'(0));
    en = 1'b0;
    @(negedge clk);
    chk("dis_sck", 64'(sck), 64'(0));
    chk("dis_ws", 64'(ws), 64'(1));
    chk("dis_sdo", 64'(sdo), 64'(0));
    uf_clr = 1'b1;
    @(negedge clk);
    uf_clr = 1'b0;
    chk("uf_cleared", 64'(uf), 64'(0));

    // I2S stereo, 16-bit samples
    lj = 1'b0; mon_lj = 1'b0; ssz = 6'd16; ch = CH_STEREO;
    mon_gen++;
    push_word(32'h0000_A5A5); exp_q.push_back(mk(WS_LEFT, 32'hA5A5_0000));
    push_word(32'h0000_3C3C); exp_q.push_back(mk(~WS_LEFT, 32'h3C3C_0000));
    exp_q.push_back(mk(WS_LEFT, 32'h0));
    exp_q.push_back(mk(~WS_LEFT, 32'h0));
    chk("i2s_level2", 64'(bus.fifo_level), 64'(2));
    chk("i2s_below", 64'(bus.fifo_level_below), 64'(1));
    en = 1'b1;
    drain("i2s");
    chk("i2s_level0", 64'(bus.fifo_level), 64'(0));
    en = 1'b0;
    @(negedge clk);

    // Left-justified: MSB on sdo together with the ws fall
    lj = 1'b1; mon_lj = 1'b1;
    mon_gen++;
    push_word(32'h0000_A5A5); exp_q.push_back(mk(WS_LEFT, 32'hA5A5_0000));
    push_word(32'h0000_3C3C); exp_q.push_back(mk(~WS_LEFT, 32'h3C3C_0000));
    exp_q.push_back(mk(WS_LEFT, 32'h0));
    en = 1'b1;
    wait_ws(1'b0, "lj_ws_left");
    chk("lj_msb", 64'(sdo), 64'(1));
    drain("lj");
    en = 1'b0;
    @(negedge clk);

    // Left channel only: one pop per frame, right slots silent
    lj = 1'b0; mon_lj = 1'b0; ch = CH_LEFT;
    mon_gen++;
    w4[0] = 32'h0000_1234; w4[1] = 32'h0000_BEEF;
    w4[2] = 32'h0000_0F0F; w4[3] = 32'h0000_8001;
    for (int i = 0; i < 4; i++) begin
      push_word(w4[i]);
      exp_q.push_back(mk(WS_LEFT, w4[i] << 16));
      exp_q.push_back(mk(~WS_LEFT, 32'h0));
    end
    chk("left_level4", 64'(bus.fifo_level), 64'(4));
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      e = exp_q.pop_front();
      next_cap("left_only", o, got);
      if (got) begin
        chk($sformatf("left_only[%0d]", k), 64'(o), 64'(e));
        chk($sformatf("left_lvl[%0d]", k), 64'(bus.fifo_level), 64'(lvl_after(k)));
      end
    end
    en = 1'b0;
    @(negedge clk);

    // Full FIFO, dropped 17th push, 32-bit (size 0) left-justified drain
    lj = 1'b1; mon_lj = 1'b1; ssz = 6'd0; ch = CH_STEREO;
    mon_gen++;
    for (int i = 0; i < 16; i++) begin
      w = {8'(i + 1), ~8'(i), 16'h5AC3};
      push_word(w);
      exp_q.push_back(mk((i % 2) != 0, w));
      if (i == 6) chk("below_at_7", 64'(bus.fifo_level_below), 64'(1));
      if (i == 7) chk("below_at_8", 64'(bus.fifo_level_below), 64'(0));
    end
    chk("full_flag", 64'(bus.fifo_full), 64'(1));
    chk("full_level", 64'(bus.fifo_level), 64'(16));
    chk("full_empty", 64'(bus.fifo_empty), 64'(0));
    push_word(32'hDEAD_BEEF);
    exp_q.push_back(mk(WS_LEFT, 32'h0));
    chk("drop_level", 64'(bus.fifo_level), 64'(16));
    chk("drop_full", 64'(bus.fifo_full), 64'(1));
    en = 1'b1;
    drain("full32");
    chk("full32_level0", 64'(bus.fifo_level), 64'(0));
    chk("full32_empty", 64'(bus.fifo_empty), 64'(1));
    en = 1'b0;
    @(negedge clk);

    // Flush beats a simultaneous push, both when full and when empty
    for (int i = 0; i < 16; i++) push_word(32'h1111_0000 + 32'(i));
    chk("refill_full", 64'(bus.fifo_full), 64'(1));
    bus.fifo_clr = 1'b1; bus.fifo_wr = 1'b1; bus.fifo_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.fifo_clr = 1'b0; bus.fifo_wr = 1'b0;
    chk("clr_full_level", 64'(bus.fifo_level), 64'(0));
    chk("clr_full_empty", 64'(bus.fifo_empty), 64'(1));
    chk("clr_below", 64'(bus.fifo_level_below), 64'(1));
    bus.fifo_clr = 1'b1; bus.fifo_wr = 1'b1;
    @(negedge clk);
    bus.fifo_clr = 1'b0; bus.fifo_wr = 1'b0;
    chk("clr_empty_level", 64'(bus.fifo_level), 64'(0));

    // Underflow: sticky, and set beats a coincident clear
    uf_clr = 1'b1;
    @(negedge clk);
    uf_clr = 1'b0;
    chk("uf_pre_clear", 64'(uf), 64'(0));
    en = 1'b1;
    wait_ws(1'b0, "uf_ws_left");
    chk("uf_set", 64'(uf), 64'(1));
    repeat (60) @(negedge clk);
    uf_clr = 1'b1;
    @(negedge clk);
    uf_clr = 1'b0;
    chk("uf_mid_clear", 64'(uf), 64'(0));
    repeat (66) @(negedge clk);
    uf_clr = 1'b1;
    @(negedge clk);
    uf_clr = 1'b0;
    chk("uf_coinc_ws", 64'(ws), 64'(1));
    chk("uf_coinc_set", 64'(uf), 64'(1));
    repeat (10) @(negedge clk);
    chk("uf_held", 64'(uf), 64'(1));
    en = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
